dds_phase_gen: RTL

Phase-accumulator address generator that sits directly upstream of the 512×8 waveform ROM in the DSO FPGA and also consumes its output. It steps a 32-bit phase accumulator at a programmable sample rate and drives the ROM address. It re-aligns the ROM's 2-cycle registered read data into a sample stream with a valid strobe and a cycle-start marker. Downstream consumers are the test-signal DAC path and the trigger self-test.

---
 rtl/dso_pkg.sv | 15 +
 rtl/tick_prescaler.sv | 27 ++
 rtl/dds_phase_gen.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/dso_pkg.sv
// Shared DSO constants and the phase-generator state encoding.
package dso_pkg;

   localparam int ACC_W   = 32;
   localparam int ADDR_W  = 9;
   localparam int DATA_W  = 8;
   localparam int DIV_W   = 16;
   localparam int ROM_LAT = 2;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Sample-rate prescaler: counts 0..div and issues a tick on the terminal count.
module tick_prescaler #(
   parameter int DIV_W = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             clear,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] count;

   assign tick = ~clear & (count == div);

   // A count above a freshly lowered div wraps to 0 instead of running on.
   always_ff @(posedge clock) begin
      if (!reset_n || clear) begin
         count <= '0;
      end else if (count >= div) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/dds_phase_gen.sv
// Phase-accumulator ROM address generator with shadowed configuration and a
// valid pipeline that re-aligns registered ROM data into a sample stream.
module dds_phase_gen #(
   parameter int ACC_W   = dso_pkg::ACC_W,
   parameter int ADDR_W  = dso_pkg::ADDR_W,
   parameter int DATA_W  = dso_pkg::DATA_W,
   parameter int DIV_W   = dso_pkg::DIV_W,
   parameter int ROM_LAT = dso_pkg::ROM_LAT
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              run,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [ACC_W-1:0]  cfg_ftw,
   input  logic [ADDR_W-1:0] cfg_phase,
   input  logic [DIV_W-1:0]  cfg_div,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_q,
   output logic [DATA_W-1:0] sample,
   output logic              sample_valid,
   output logic              cycle_start
);

   import dso_pkg::*;

   state_t state, state_next;

   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  ftw_a, ftw_s;
   logic [ADDR_W-1:0] phase_a, phase_s;
   logic [DIV_W-1:0]  div_a, div_s;
   logic              pending;
   logic              accept;
   logic              load;
   logic              presc_clear;
   logic              presc_tick;
   logic              tick;
   logic [ACC_W:0]    sum;
   logic              wrap;
   logic [ROM_LAT:0]  tick_pipe;
   logic [ROM_LAT:0]  wrap_pipe;
   logic              held_wrap;

   tick_prescaler #(
      .DIV_W (DIV_W)
   ) u_prescaler (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (presc_clear),
      .div     (div_a),
      .tick    (presc_tick)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next  = state;
      presc_clear = 1'b1;
      tick        = 1'b0;
      case (state)
         IDLE: begin
            if (run) begin
               state_next = RUN;
            end
         end
         RUN: begin
            presc_clear = 1'b0;
            tick        = presc_tick;
            if (!run) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign sum       = {1'b0, acc} + {1'b0, ftw_a};
   assign wrap      = sum[ACC_W];
   assign cfg_ready = ~pending;
   assign accept    = cfg_valid & ~pending;

   // Shadow promotes when idle, on a wrapping tick, or on any tick while a
   // zero step would otherwise never wrap.
   assign load = pending & ((state == IDLE) | (tick & (wrap | (ftw_a == '0))));

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         pending <= 1'b0;
         ftw_s   <= '0;
         phase_s <= '0;
         div_s   <= '0;
         ftw_a   <= '0;
         phase_a <= '0;
         div_a   <= '0;
      end else begin
         if (accept) begin
            pending <= 1'b1;
            ftw_s   <= cfg_ftw;
            phase_s <= cfg_phase;
            div_s   <= cfg_div;
         end else if (load) begin
            pending <= 1'b0;
         end
         if (load) begin
            ftw_a   <= ftw_s;
            phase_a <= phase_s;
            div_a   <= div_s;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         acc       <= '0;
         rom_addr  <= '0;
         tick_pipe <= '0;
         wrap_pipe <= '0;
      end else begin
         if (state == IDLE) begin
            acc <= '0;
         end else if (tick) begin
            acc      <= sum[ACC_W-1:0];
            rom_addr <= acc[ACC_W-1 -: ADDR_W] + phase_a;
         end
         tick_pipe <= {tick_pipe[ROM_LAT-1:0], tick};
         wrap_pipe <= {wrap_pipe[ROM_LAT-1:0], tick & wrap};
      end
   end

   // A wrap belongs to the last sample of a period, so it marks the next one.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         sample       <= '0;
         sample_valid <= 1'b0;
         cycle_start  <= 1'b0;
         held_wrap    <= 1'b0;
      end else begin
         sample_valid <= tick_pipe[ROM_LAT];
         if (tick_pipe[ROM_LAT]) begin
            sample      <= rom_q;
            cycle_start <= held_wrap;
            held_wrap   <= wrap_pipe[ROM_LAT];
         end else begin
            cycle_start <= 1'b0;
         end
      end
   end

endmodule
